// File: rtl/rv_pkg.sv
// Shared RV32 front-end types: instruction word, fetch FSM states, reset vector.
`timescale 1ns/1ps
package rv;

  typedef logic [31:0] RV32_INSTRUCTION;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,  // request presented at pc
    WAIT    = 2'd1,  // one request outstanding, response will be kept
    HOLD    = 2'd2,  // instruction offered to the decoder
    DISCARD = 2'd3   // one request outstanding, response will be dropped
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait, hand one word to decode.
// Redirects retarget pc immediately; an in-flight response for a stale
// address is drained in DISCARD so it never reaches the decoder.
`timescale 1ns/1ps
module fetch_unit
  import rv::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output RV32_INSTRUCTION instruction,
  output logic [31:0]     instr_pc
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic         capture;

  // Low address bits of a redirect target are don't-care.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);

  // Next state / next pc; a redirect overrides any sequential pc advance.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    capture = 1'b0;
    case (state)
      FETCH: begin
        if (imem_gnt) state_n = redirect_valid ? DISCARD : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            state_n = FETCH;
          end else begin
            state_n = HOLD;
            capture = 1'b1;
            pc_n    = pc + 32'd4;
          end
        end else if (redirect_valid) begin
          state_n = DISCARD;
        end
      end
      HOLD: begin
        if (redirect_valid || instr_ready) state_n = FETCH;
      end
      DISCARD: begin
        if (imem_rvalid) state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
    if (redirect_valid) pc_n = {redirect_pc[31:2], 2'b00};
  end

  // State, pc and the decoder-facing instruction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= {RESET_PC[31:2], 2'b00};
      instruction <= '0;
      instr_pc    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (capture) begin
        instruction <= imem_rdata;
        instr_pc    <= pc;
      end
    end
  end

`ifndef SYNTHESIS
  // A response is only legal while a request is actually outstanding.
  rvalid_in_window: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (state == WAIT || state == DISCARD));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model of the fetch stream plus a
// latency-randomized single-outstanding memory, with directed scenarios.
`timescale 1ns/1ps
module tb_fetch_unit;
  import rv::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            imem_req;
  logic [31:0]     imem_addr;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            redirect_valid = 1'b0;
  logic [31:0]     redirect_pc = '0;
  logic            instr_valid;
  logic            instr_ready = 1'b0;
  RV32_INSTRUCTION instruction;
  logic [31:0]     instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus knobs (percent probabilities; lat_fix=0 means random 1..3).
  int p_gnt = 100, p_ready = 100, p_redir = 0, lat_fix = 1;

  // Memory contents are a fixed hash of the address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory side: one outstanding request, response after lat cycles.
  logic        mem_out = 1'b0;
  logic [31:0] mem_addr = '0;
  int          age = 0, lat = 1;
  int          cycn = 0;
  logic [31:0] gnt_log[$];
  logic [31:0] xfer_pc[$];
  int          xfer_cyc[$];

  // Model of what the decoder must see: the pending fetch, whether its
  // response is still wanted, and the word currently offered.
  logic [31:0] m_pc = '0, m_instr = '0, m_ipc = '0;
  logic        m_out = 1'b0, m_live = 1'b0, m_hold = 1'b0;

  // Memory bookkeeping, logs and model advance on each rising edge.
  always @(posedge clk) begin
    cycn <= cycn + 1;
    if (rst) begin
      mem_out <= 1'b0;
      m_pc <= 32'h0; m_out <= 1'b0; m_live <= 1'b0; m_hold <= 1'b0;
      m_instr <= '0; m_ipc <= '0;
    end else begin
      if (mem_out && imem_rvalid) mem_out <= 1'b0;
      else if (mem_out) age <= age + 1;
      if (imem_req && imem_gnt) begin
        mem_out  <= 1'b1;
        mem_addr <= imem_addr;
        age      <= 0;
        lat      <= (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
        gnt_log.push_back(imem_addr);
      end
      if (instr_valid && instr_ready) begin
        xfer_pc.push_back(instr_pc);
        xfer_cyc.push_back(cycn);
      end
      // model: offered word leaves on transfer or redirect
      if (m_hold && (redirect_valid || instr_ready)) m_hold <= 1'b0;
      // response arrives: kept only if still wanted and not redirected now
      if (m_out && imem_rvalid) begin
        m_out <= 1'b0;
        if (m_live && !redirect_valid) begin
          m_hold  <= 1'b1;
          m_instr <= memword(m_pc);
          m_ipc   <= m_pc;
          m_pc    <= m_pc + 32'd4;
        end
      end
      // a request is accepted whenever nothing is pending or offered
      if (!m_out && !m_hold && imem_gnt) begin
        m_out  <= 1'b1;
        m_live <= !redirect_valid;
      end
      if (redirect_valid) begin
        m_pc   <= {redirect_pc[31:2], 2'b00};
        m_live <= 1'b0;
      end
    end
  end

  // Compare DUT outputs against the model every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("imem_req", {31'b0, imem_req}, {31'b0, !m_out && !m_hold});
      check("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
      if (imem_req) check("imem_addr", imem_addr, m_pc);
      check("instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
      if (m_hold) begin
        check("instruction", instruction, m_instr);
        check("instr_pc", instr_pc, m_ipc);
      end
    end
  end

  task automatic drive();
    imem_gnt       = ($urandom_range(0, 99) < p_gnt);
    instr_ready    = ($urandom_range(0, 99) < p_ready);
    redirect_valid = ($urandom_range(0, 99) < p_redir);
    redirect_pc    = $urandom;
    imem_rvalid    = mem_out && (age >= lat - 1);
    imem_rdata     = imem_rvalid ? memword(mem_addr) : $urandom;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_i, hold_pc;
    int idx;
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    #1 rst = 1'b0;
    check("rel_imem_req", {31'b0, imem_req}, 32'h1);
    check("rel_imem_addr", imem_addr, 32'h0);
    drive();

    // Sequential stream, 1-cycle memory, decoder always ready
    repeat (10) cyc();
    check("seq_ngnt", {31'b0, gnt_log.size() >= 3}, 32'h1);
    check("seq_nxfer", {31'b0, xfer_pc.size() >= 3}, 32'h1);
    if (gnt_log.size() >= 3 && xfer_pc.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check("seq_gnt_addr", gnt_log[i], 32'(4 * i));
        check("seq_xfer_pc", xfer_pc[i], 32'(4 * i));
      end
      check("seq_period1", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd3);
      check("seq_period2", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd3);
    end

    // Decoder stalls in HOLD
    p_ready = 0; instr_ready = 1'b0;
    for (int k = 0; k < 20 && !instr_valid; k++) cyc();
    check("stall_reach_hold", {31'b0, instr_valid}, 32'h1);
    hold_i = instruction; hold_pc = instr_pc;
    check("stall_word", hold_i, memword(hold_pc));
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("stall_instr", instruction, hold_i);
      check("stall_pc", instr_pc, hold_pc);
      check("stall_req", {31'b0, imem_req}, 32'h0);
      check("stall_valid", {31'b0, instr_valid}, 32'h1);
    end
    p_ready = 100;

    // Redirect to 0x103 while a request waits
    lat_fix = 3;
    for (int k = 0; k < 30 && !(mem_out && !imem_rvalid); k++) cyc();
    check("wait_reached", {31'b0, mem_out}, 32'h1);
    gnt_log.delete(); xfer_pc.delete(); xfer_cyc.delete();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    for (int k = 0; k < 30 && xfer_pc.size() == 0; k++) cyc();
    check("redir_nxfer", {31'b0, xfer_pc.size() != 0}, 32'h1);
    if (xfer_pc.size() != 0) check("redir_first_pc", xfer_pc[0], 32'h100);
    if (gnt_log.size() != 0) check("redir_first_gnt", gnt_log[0], 32'h100);

    // Redirect in the same cycle as the response
    lat_fix = 1;
    for (int k = 0; k < 30 && !imem_rvalid; k++) cyc();
    check("rv_reached", {31'b0, imem_rvalid}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    cyc();
    check("rvredir_valid", {31'b0, instr_valid}, 32'h0);
    check("rvredir_req", {31'b0, imem_req}, 32'h1);
    check("rvredir_addr", imem_addr, 32'h200);

    // Wrap at the top of the address space
    gnt_log.delete();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    for (int k = 0; k < 40 && gnt_log.size() < 3; k++) cyc();
    idx = -1;
    for (int i = 0; i < gnt_log.size(); i++)
      if (idx < 0 && gnt_log[i] == 32'hFFFF_FFFC) idx = i;
    check("wrap_found", {31'b0, idx >= 0 && idx + 1 < gnt_log.size()}, 32'h1);
    if (idx >= 0 && idx + 1 < gnt_log.size()) check("wrap_next", gnt_log[idx + 1], 32'h0);

    // Reset while a request is outstanding; response arrives during reset
    lat_fix = 3;
    for (int k = 0; k < 30 && !(mem_out && !imem_rvalid); k++) cyc();
    check("rstwait_reached", {31'b0, mem_out}, 32'h1);
    rst = 1'b1;
    @(negedge clk); #1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    imem_rvalid = 1'b0;
    rst = 1'b0;
    #1;
    check("rstmid_valid", {31'b0, instr_valid}, 32'h0);
    check("rstmid_req", {31'b0, imem_req}, 32'h1);
    check("rstmid_addr", imem_addr, 32'h0);
    drive();

    // Random traffic
    p_gnt = 60; p_ready = 60; p_redir = 8; lat_fix = 0;
    repeat (3000) cyc();
    p_redir = 0; redirect_valid = 1'b0;
    repeat (10) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
